// File: rtl/sram_bus_slave_pkg.sv
// Shared definitions for the SRAM bus responder: address width, default
// wait-cycle count, FSM state encoding and the registered pad-strobe bundle.
`ifndef SRAM_ADDRESS_WIDTH
`define SRAM_ADDRESS_WIDTH 20
`endif

package sram_bus_slave_pkg;

    localparam int SRAM_ADDR_W       = `SRAM_ADDRESS_WIDTH;
    localparam int SRAM_WAIT_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_WRITE     = 3'd2,
        ST_WRITE_REC = 3'd3,
        ST_DONE      = 3'd4
    } SramState_t;

    // Pad control lines that are registered together every cycle.
    typedef struct packed {
        logic       ce_n;
        logic       oe_n;
        logic       we_n;
        logic       data_t;
        logic [3:0] be_n;
    } SramStrobe_t;

    // Quiescent pad state: chip deselected, bus released.
    localparam SramStrobe_t STROBE_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                           data_t: 1'b1, be_n: 4'hF};

endpackage

// File: rtl/sram_bus_slave_if.sv
// Single-word blocking system bus; the master holds a request until stall drops.
interface Bus_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] data_wr;
    logic [3:0]  mask;
    logic        stall;
    logic [31:0] data_rd;
    logic [31:0] data_rd_2;

    modport master (
        output address, read, write, data_wr, mask,
        input  stall, data_rd, data_rd_2
    );

    modport slave (
        input  address, read, write, data_wr, mask,
        output stall, data_rd, data_rd_2
    );
endinterface

// File: rtl/sram_bus_slave.sv
// Bus responder driving one asynchronous 32-bit SRAM bank. Each access holds
// the strobes for WAIT_CYCLES cycles; writes add one recovery cycle with data
// still driven so the SRAM sees hold time after we_n rises. All pad outputs
// come straight from flops.
module sram_bus_slave
    import sram_bus_slave_pkg::*;
#(
    parameter int WAIT_CYCLES = SRAM_WAIT_DEFAULT,
    parameter int ADDR_WIDTH  = SRAM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    Bus_if.slave                  bus,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [31:0]           sram_data_i,
    output logic [31:0]           sram_data_o,
    output logic                  sram_data_t,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [3:0]            sram_be_n
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    SramState_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            mask_q, mask_d;
    logic [31:0]           rdata_q, rdata_d;
    SramStrobe_t           strobe_q, strobe_d;

    // Byte-offset and high address bits are decoded elsewhere.
    logic unused_addr_s;
    assign unused_addr_s = ^{bus.address[31:ADDR_WIDTH+2], bus.address[1:0]};

    // State register and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: write wins over read; counter runs down in strobe states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.write) begin
                    state_d = ST_WRITE;
                    cnt_d   = WAIT_LOAD;
                end else if (bus.read) begin
                    state_d = ST_READ;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_WRITE_REC;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WRITE_REC: state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output logic: pad values for the upcoming state, so they are registered.
    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        rdata_d  = rdata_q;
        strobe_d = STROBE_IDLE;
        if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) begin
            addr_d  = bus.address[ADDR_WIDTH+1:2];
            wdata_d = bus.data_wr;
            mask_d  = bus.mask;
        end else begin
            addr_d  = addr_q;
            wdata_d = wdata_q;
            mask_d  = mask_q;
        end
        // Sample the pad on the last cycle oe_n is low.
        if ((state_q == ST_READ) && (cnt_q == 4'd0)) begin
            rdata_d = sram_data_i;
        end else begin
            rdata_d = rdata_q;
        end
        case (state_d)
            ST_READ: strobe_d = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1,
                                  data_t: 1'b1, be_n: 4'b0000};
            // An all-zero mask still runs the cycle but never pulses we_n.
            ST_WRITE: strobe_d = '{ce_n: 1'b0, oe_n: 1'b1,
                                   we_n: (mask_d == 4'b0000),
                                   data_t: 1'b0, be_n: ~mask_d};
            ST_WRITE_REC: strobe_d = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1,
                                       data_t: 1'b0, be_n: ~mask_d};
            default: strobe_d = STROBE_IDLE;
        endcase
    end

    // Datapath and pad registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            mask_q   <= 4'h0;
            rdata_q  <= 32'h0;
            strobe_q <= STROBE_IDLE;
        end else begin
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mask_q   <= mask_d;
            rdata_q  <= rdata_d;
            strobe_q <= strobe_d;
        end
    end

    assign sram_addr    = addr_q;
    assign sram_data_o  = wdata_q;
    assign sram_data_t  = strobe_q.data_t;
    assign sram_ce_n    = strobe_q.ce_n;
    assign sram_oe_n    = strobe_q.oe_n;
    assign sram_we_n    = strobe_q.we_n;
    assign sram_be_n    = strobe_q.be_n;

    assign bus.stall     = rst_n & (bus.read | bus.write) & (state_q != ST_DONE);
    assign bus.data_rd   = rdata_q;
    assign bus.data_rd_2 = 32'h0;

endmodule

// File: tb/tb_sram_bus_slave.sv
// Bench for sram_bus_slave: a WAIT_CYCLES=2 instance driven from a vector
// table plus a reset-mid-write sequence, and a WAIT_CYCLES=1 instance for
// back-to-back reads. Read data is checked through a scoreboard queue.
module tb_sram_bus_slave;
    import sram_bus_slave_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    Bus_if bus0 ();
    Bus_if bus1 ();

    // Request lines shared by both instances; sel steers them.
    logic        sel;
    logic        rq_rd, rq_wr;
    logic [31:0] rq_addr, rq_wdata;
    logic [3:0]  rq_mask;

    assign bus0.read    = rq_rd & ~sel;
    assign bus0.write   = rq_wr & ~sel;
    assign bus0.address = rq_addr;
    assign bus0.data_wr = rq_wdata;
    assign bus0.mask    = rq_mask;
    assign bus1.read    = rq_rd & sel;
    assign bus1.write   = rq_wr & sel;
    assign bus1.address = rq_addr;
    assign bus1.data_wr = rq_wdata;
    assign bus1.mask    = rq_mask;

    logic [19:0] a0, a1;
    logic [31:0] di0, do0, di1, do1;
    logic        t0, ce0, oe0, we0, t1, ce1, oe1, we1;
    logic [3:0]  be0, be1;

    sram_bus_slave #(.WAIT_CYCLES(2), .ADDR_WIDTH(20)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .sram_addr(a0),
        .sram_data_i(di0), .sram_data_o(do0), .sram_data_t(t0),
        .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0), .sram_be_n(be0));

    sram_bus_slave #(.WAIT_CYCLES(1), .ADDR_WIDTH(20)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .sram_addr(a1),
        .sram_data_i(di1), .sram_data_o(do1), .sram_data_t(t1),
        .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1), .sram_be_n(be1));

    // Observation mux for the selected instance.
    logic        st_s, ce_s, oe_s, we_s, t_s;
    logic [3:0]  be_s;
    logic [19:0] addr_s;
    logic [31:0] do_s, rd_s;
    assign st_s   = sel ? bus1.stall   : bus0.stall;
    assign rd_s   = sel ? bus1.data_rd : bus0.data_rd;
    assign ce_s   = sel ? ce1 : ce0;
    assign oe_s   = sel ? oe1 : oe0;
    assign we_s   = sel ? we1 : we0;
    assign t_s    = sel ? t1  : t0;
    assign be_s   = sel ? be1 : be0;
    assign addr_s = sel ? a1  : a0;
    assign do_s   = sel ? do1 : do0;

    // Asynchronous SRAM models (1K words each), reference memory for dut0.
    bit [31:0] mem0 [1024];
    bit [31:0] mem1 [1024];
    bit [31:0] ref_mem [1024];

    assign di0 = (!ce0 && !oe0) ? mem0[a0[9:0]] : 32'h0;
    assign di1 = (!ce1 && !oe1) ? mem1[a1[9:0]] : 32'h0;

    // Write commits on the rising edge of we_n; a rise caused by reset is an aborted write.
    always @(posedge we0) begin
        if (rst_n && !ce0) begin
            for (int b = 0; b < 4; b++) begin
                if (!be0[b]) mem0[a0[9:0]][b*8 +: 8] = do0[b*8 +: 8];
            end
        end
    end

    function automatic bit [31:0] pat0(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    endfunction
    function automatic bit [31:0] pat1(input int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h0003_0007);
    endfunction

    logic [31:0] exp_q [$];
    logic [31:0] last_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          cycles;
        int          oe_cnt;
        int          we_cnt;
        logic [3:0]  be_n;
    } vec_t;

    function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] mask,
                                input int cycles, input int oe_cnt, input int we_cnt,
                                input logic [3:0] be_n);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.mask = mask;
        v.cycles = cycles; v.oe_cnt = oe_cnt; v.we_cnt = we_cnt; v.be_n = be_n;
        return v;
    endfunction

    // One blocking access, starting on the next rising edge; cycle 0 is the request cycle.
    task automatic access(input bit s, input vec_t v, input string tag);
        int          cyc, oe_cnt, we_cnt, drv_cnt, first_strobe;
        bit          done, stable;
        logic [3:0]  be_seen;
        logic [19:0] addr_seen;
        logic [31:0] do_seen, exp_rd;
        int          idx;
        idx = int'(v.addr[11:2]);
        @(posedge clk); #1;
        sel = s; rq_rd = v.rd; rq_wr = v.wr;
        rq_addr = v.addr; rq_wdata = v.wdata; rq_mask = v.mask;
        if (v.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (v.mask[b]) ref_mem[idx][b*8 +: 8] = v.wdata[b*8 +: 8];
            end
        end else begin
            exp_q.push_back(s ? pat1(idx) : ref_mem[idx]);
        end
        cyc = 0; done = 1'b0; stable = 1'b1;
        oe_cnt = 0; we_cnt = 0; drv_cnt = 0; first_strobe = -1;
        be_seen = 4'h0; addr_seen = 20'h0; do_seen = 32'h0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (!oe_s) oe_cnt++;
            if (!we_s) we_cnt++;
            if (!t_s)  drv_cnt++;
            if (!ce_s) begin
                if (first_strobe < 0) begin
                    first_strobe = cyc; be_seen = be_s; addr_seen = addr_s; do_seen = do_s;
                end else if (be_s !== be_seen || addr_s !== addr_seen ||
                             (v.wr && do_s !== do_seen)) begin
                    stable = 1'b0;
                end
            end
            cyc++;
            if (!st_s) done = 1'b1;
        end
        rq_rd = 1'b0; rq_wr = 1'b0;
        chk({tag, " completes"}, 64'(done), 64'd1);
        chk({tag, " latency"}, 64'(cyc), 64'(v.cycles));
        chk({tag, " oe_n low cycles"}, 64'(oe_cnt), 64'(v.oe_cnt));
        chk({tag, " we_n low cycles"}, 64'(we_cnt), 64'(v.we_cnt));
        chk({tag, " first strobe cycle"}, 64'(first_strobe), 64'd1);
        chk({tag, " be_n"}, 64'(be_seen), 64'(v.be_n));
        chk({tag, " sram_addr"}, 64'(addr_seen), 64'(v.addr[21:2]));
        chk({tag, " strobe-window stability"}, 64'(stable), 64'd1);
        chk({tag, " data driven cycles"}, 64'(drv_cnt), v.wr ? 64'(v.cycles - 2) : 64'd0);
        if (v.wr) begin
            chk({tag, " write data"}, 64'(do_seen), 64'(v.wdata));
            chk({tag, " data_rd held"}, 64'(rd_s), 64'(last_rd));
            if (!s) chk({tag, " sram contents"}, 64'(mem0[idx]), 64'(ref_mem[idx]));
        end else begin
            exp_rd = exp_q.pop_front();
            chk({tag, " data_rd"}, 64'(rd_s), 64'(exp_rd));
            last_rd = exp_rd;
        end
    endtask

    vec_t vecs [10];
    vec_t v;
    time  t_start;

    initial begin
        sel = 1'b0; rq_rd = 1'b0; rq_wr = 1'b0;
        rq_addr = 32'h0; rq_wdata = 32'h0; rq_mask = 4'h0;
        last_rd = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            mem0[i] = pat0(i); ref_mem[i] = pat0(i); mem1[i] = pat1(i);
        end
        mem0[4]  = 32'hDEADBEEF; ref_mem[4]  = 32'hDEADBEEF;
        mem0[8]  = 32'hAABBCCDD; ref_mem[8]  = 32'hAABBCCDD;
        mem0[16] = 32'h55555555; ref_mem[16] = 32'h55555555;
        mem0[20] = 32'h0BADF00D; ref_mem[20] = 32'h0BADF00D;

        //                rd    wr    address        wdata          mask     cyc oe we be_n
        vecs[0] = mk(1'b1, 1'b0, 32'h0000_0010, 32'h0,          4'hF,    4, 2, 0, 4'b0000);
        vecs[1] = mk(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678,  4'b0011, 5, 0, 2, 4'b1100);
        vecs[2] = mk(1'b1, 1'b0, 32'h0000_0020, 32'h0,          4'h0,    4, 2, 0, 4'b0000);
        vecs[3] = mk(1'b1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D,  4'hF,    5, 0, 2, 4'b0000);
        vecs[4] = mk(1'b1, 1'b0, 32'h0000_0030, 32'h0,          4'h0,    4, 2, 0, 4'b0000);
        vecs[5] = mk(1'b0, 1'b1, 32'h0000_0040, 32'h1111_1111,  4'b0000, 5, 0, 0, 4'b1111);
        vecs[6] = mk(1'b1, 1'b0, 32'h0000_0040, 32'h0,          4'h0,    4, 2, 0, 4'b0000);
        vecs[7] = mk(1'b0, 1'b1, 32'h003F_FFFC, 32'h8765_4321,  4'b1001, 5, 0, 2, 4'b0110);
        vecs[8] = mk(1'b1, 1'b0, 32'h003F_FFFC, 32'h0,          4'h0,    4, 2, 0, 4'b0000);
        vecs[9] = mk(1'b1, 1'b0, 32'hFF00_0014, 32'h0,          4'h0,    4, 2, 0, 4'b0000);

        // Reset state, with a request present to show stall is forced low.
        rst_n = 1'b0;
        rq_rd = 1'b1;
        #12;
        chk("reset stall", 64'(bus0.stall), 64'd0);
        chk("reset strobes ce/oe/we/t", 64'({ce0, oe0, we0, t0}), 64'hF);
        chk("reset be_n", 64'(be0), 64'hF);
        chk("reset addr/data", 64'({a0, do0}), 64'd0);
        chk("reset data_rd", 64'(bus0.data_rd), 64'd0);
        rq_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            access(1'b0, vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted during the second WRITE cycle abandons the write.
        @(posedge clk); #1;
        sel = 1'b0; rq_wr = 1'b1; rq_rd = 1'b0;
        rq_addr = 32'h0000_0050; rq_wdata = 32'hFFFF_FFFF; rq_mask = 4'hF;
        @(posedge clk);
        @(posedge clk); #2;
        chk("midwrite we_n low before reset", 64'(we0), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midwrite reset strobes ce/oe/we/t", 64'({ce0, oe0, we0, t0}), 64'hF);
        chk("midwrite reset be_n", 64'(be0), 64'hF);
        chk("midwrite reset stall", 64'(bus0.stall), 64'd0);
        chk("midwrite reset data_rd", 64'(bus0.data_rd), 64'd0);
        rq_wr = 1'b0;
        last_rd = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        v = mk(1'b1, 1'b0, 32'h0000_0050, 32'h0, 4'h0, 4, 2, 0, 4'b0000);
        access(1'b0, v, "read after abort");

        // WAIT_CYCLES=1: eight back-to-back reads, three cycles each.
        @(posedge clk);
        @(negedge clk);
        t_start = $time;
        for (int i = 0; i < 8; i++) begin
            v = mk(1'b1, 1'b0, 32'h0000_0100 + 32'(i) * 32'd4, 32'h0, 4'h0, 3, 1, 0, 4'b0000);
            access(1'b1, v, $sformatf("b2b%0d", i));
        end
        chk("b2b total time", 64'($time - t_start), 64'd240);
        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
